// File: rtl/clk_div_ctrl.sv
// Programmable clock-divide controller: registered divided clock, per-period enable
// pulse, and boundary-aligned ratio changes through a valid/ready handshake.
module clk_div_ctrl #(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             clk_en,
  output logic             busy,
  output logic [DIV_W-1:0] div_active
);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] cnt, cnt_next;
  logic [DIV_W-1:0] ratio, ratio_next;
  logic [DIV_W-1:0] shadow, shadow_next;
  logic             pend_vld, pend_next;
  logic             out_next, en_next, err_next;
  logic             accept, legal, boundary;
  logic [DIV_W:0]   half;

  always_comb begin
    accept      = cfg_valid && !pend_vld;
    legal       = cfg_div >= DIV_W'(2);
    boundary    = (state != IDLE) && (cnt == ratio - 1'b1);
    half        = ({1'b0, ratio} + 1'b1) >> 1;
    // Outputs lag the counter by one edge so every output leaves a flop.
    out_next    = (state != IDLE) && ({1'b0, cnt} < half);
    en_next     = (state != IDLE) && (cnt == '0);
    err_next    = accept && !legal;
    state_next  = state;
    cnt_next    = cnt;
    ratio_next  = ratio;
    shadow_next = shadow;
    pend_next   = pend_vld;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (accept && legal) ratio_next = cfg_div;
        if (run) state_next = RUN;
      end
      RUN: begin
        if (!run) state_next = STOP_PEND;
      end
      STOP_PEND: begin
        if (boundary) state_next = IDLE;
        else if (run) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase

    // While counting, a pending ratio only ever lands on a period boundary.
    if (state != IDLE) begin
      if (boundary) begin
        cnt_next = '0;
        if (pend_vld) begin
          ratio_next = shadow;
          pend_next  = 1'b0;
        end
      end else begin
        cnt_next = cnt + 1'b1;
      end
      if (accept && legal) begin
        shadow_next = cfg_div;
        pend_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ratio    <= DIV_W'(DIV_RST);
      shadow   <= '0;
      pend_vld <= 1'b0;
      clk_out  <= 1'b0;
      clk_en   <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ratio    <= ratio_next;
      shadow   <= shadow_next;
      pend_vld <= pend_next;
      clk_out  <= out_next;
      clk_en   <= en_next;
      cfg_err  <= err_next;
    end
  end

  assign busy       = (state != IDLE);
  assign cfg_ready  = !pend_vld;
  assign div_active = ratio;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized run/config
// traffic, all compared against a behavioural period model.
module tb_clk_div_ctrl;

  localparam int DIV_W   = 8;
  localparam int DIV_RST = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready, cfg_err, clk_out, clk_en, busy;
  logic [DIV_W-1:0] div_active;

  int tests = 0;
  int fails = 0;

  // Model: whether a divided clock is being produced, whether a stop is requested,
  // position within the current period, ratio in effect, and any waiting ratio.
  bit m_on, m_stopping, m_pend;
  int m_pos, m_n, m_shadow;
  bit exp_out, exp_en, exp_err;

  clk_div_ctrl #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .clk_en(clk_en),
    .busy(busy), .div_active(div_active)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_stopping = 0; m_pend = 0;
    m_pos = 0; m_n = DIV_RST; m_shadow = 0;
    exp_out = 0; exp_en = 0; exp_err = 0;
  endtask

  // One clock edge of the model, using the inputs as they stand at that edge.
  task automatic model_edge();
    bit acc, ok, at_end;
    acc     = cfg_valid && !m_pend;
    ok      = int'(cfg_div) >= 2;
    at_end  = m_on && (m_pos == m_n - 1);
    exp_out = m_on && (m_pos < (m_n + 1) / 2);
    exp_en  = m_on && (m_pos == 0);
    exp_err = acc && !ok;
    if (!m_on) begin
      m_pos = 0;
      if (acc && ok) m_n = int'(cfg_div);
      if (run) begin m_on = 1; m_stopping = 0; end
    end else begin
      if (at_end) begin
        m_pos = 0;
        if (m_pend) begin m_n = m_shadow; m_pend = 0; end
        if (m_stopping) begin m_on = 0; m_stopping = 0; end
        else if (!run) m_stopping = 1;
      end else begin
        m_pos++;
        if (run) m_stopping = 0;
        else m_stopping = 1;
      end
      if (acc && ok) begin m_shadow = int'(cfg_div); m_pend = 1; end
    end
  endtask

  task automatic check_all();
    check_output("clk_out", 32'(clk_out), 32'(exp_out));
    check_output("clk_en", 32'(clk_en), 32'(exp_en));
    check_output("cfg_err", 32'(cfg_err), 32'(exp_err));
    check_output("busy", 32'(busy), 32'(m_on));
    check_output("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    check_output("div_active", 32'(div_active), 32'(m_n));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    check_output({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    check_output({tag, "_clk_out"}, 32'(clk_out), 32'd0);
    check_output({tag, "_clk_en"}, 32'(clk_en), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_div_active"}, 32'(div_active), 32'(DIV_RST));
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then check.
  task automatic apply_stimulus(input bit r, input bit v, input int d);
    run       = r;
    cfg_valid = v;
    cfg_div   = DIV_W'(d);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(run, 1'b0, 0);
  endtask

  // Advance until the model is running at period position p (bounded).
  task automatic wait_pos(input int p);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_on && m_pos == p) found = 1;
      else apply_stimulus(run, 1'b0, 0);
    end
    if (!found) begin
      tests++;
      fails++;
      $display("[TB] FAIL wait_pos timeout observed=%0d expected=%0d", m_pos, p);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(3);

    // Default ratio 4: pattern 1,1,0,0 with an enable every 4 cycles.
    run = 1'b1;
    run_cycles(13);
    check_output("div_default", 32'(div_active), 32'd4);

    // Ratio change to 5 offered mid-period.
    wait_pos(1);
    apply_stimulus(1'b1, 1'b1, 5);
    check_output("ready_drop", 32'(cfg_ready), 32'd0);
    run_cycles(14);
    check_output("div_five", 32'(div_active), 32'd5);

    // Illegal ratios are consumed and flagged.
    apply_stimulus(1'b1, 1'b1, 1);
    check_output("err_one", 32'(cfg_err), 32'd1);
    apply_stimulus(1'b1, 1'b1, 0);
    check_output("err_zero", 32'(cfg_err), 32'd1);
    apply_stimulus(1'b1, 1'b0, 0);
    check_output("err_clear", 32'(cfg_err), 32'd0);
    check_output("div_kept", 32'(div_active), 32'd5);

    // Stop at position 1 with ratio 6: the period finishes before going idle.
    apply_stimulus(1'b1, 1'b1, 6);
    run_cycles(12);
    wait_pos(1);
    run = 1'b0;
    run_cycles(4);
    check_output("stop_busy_mid", 32'(busy), 32'd1);
    run_cycles(1);
    check_output("stop_busy_done", 32'(busy), 32'd0);
    check_output("stop_clk_out", 32'(clk_out), 32'd0);
    run_cycles(3);

    // Re-assert run while a stop is pending: no gap.
    run = 1'b1;
    run_cycles(8);
    wait_pos(2);
    apply_stimulus(1'b0, 1'b0, 0);
    run = 1'b1;
    run_cycles(20);

    // Asynchronous reset with a pending ratio of 7.
    wait_pos(1);
    apply_stimulus(1'b1, 1'b1, 7);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(20);
    check_output("div_after_reset", 32'(div_active), 32'd4);

    // Randomized run levels and config offers.
    for (int i = 0; i < 800; i++) begin
      bit r, v;
      r = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 9) < 7) r = run;
      v = ($urandom_range(0, 99) < 25);
      apply_stimulus(r, v, int'($urandom_range(0, 9)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable clock-divide controller that sequences the clock-buffer/divider path. It generates a registered divided clock and a one-cycle enable pulse per divided period. It accepts divide-ratio changes through a valid/ready handshake and applies them only on a period boundary, so no runt or stretched phase ever appears. Starting and stopping are also clean: a stop request always completes the current period first.

## Interface
- DIV_W, 8, width of the divide ratio and of the internal period counter
- DIV_RST, 4, active divide ratio after reset (must be >= 2 and < 2**DIV_W)
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = generate divided clock, 0 = stop at end of current period
- cfg_valid  input  1  new ratio offered on cfg_div
- cfg_div  input  DIV_W  requested divide ratio N (legal range 2 .. 2**DIV_W-1)
- cfg_ready  output  1  controller can accept a ratio this cycle
- cfg_err  output  1  one-cycle pulse: accepted ratio was illegal (< 2) and was discarded
- clk_out  output  1  registered divided clock, period N clk cycles
- clk_en  output  1  one-cycle pulse coincident with each rising phase of clk_out
- busy  output  1  1 whenever the state is not IDLE
- div_active  output  DIV_W  ratio currently in effect

## Operation
- Internal state: a period counter cnt (0..N-1), an active ratio N, a shadow ratio with flag pend_vld, and FSM states IDLE, RUN, STOP_PEND.
- cnt == 0 begins each period. clk_out = 1 while cnt < ceil(N/2), otherwise 0. The high phase is the longer phase for odd N.
- clk_en = 1 exactly when cnt == 0 in RUN or STOP_PEND.
- IDLE: cnt = 0, clk_out = 0, clk_en = 0. When run = 1 is sampled, go to RUN with cnt = 0.
- RUN: cnt increments and wraps at N-1. When run = 0 is sampled, go to STOP_PEND; counting continues unchanged.
- STOP_PEND: at the edge where cnt == N-1, go to IDLE (cnt = 0, clk_out = 0). If run = 1 is sampled before that edge, return to RUN with no phase disturbance.
- A handshake occurs on the edge where cfg_valid && cfg_ready.
- cfg_ready = !pend_vld.
- Accepted in IDLE: the ratio is written directly to N; pend_vld stays 0.
- Accepted in RUN or STOP_PEND: the ratio is written to the shadow and pend_vld is set.
- Apply rule: at an edge where cnt == N-1 and pend_vld is 1 (the registered value before that edge), N <= shadow, cnt <= 0, pend_vld <= 0. If a config is accepted on that same edge, it becomes pending and is applied at the following boundary.
- If a pending ratio exists when STOP_PEND reaches IDLE, it is applied on that same edge.
- Illegal ratio (cfg_div < 2): the handshake still completes. The value is discarded, N and pend_vld are unchanged, and cfg_err pulses for one cycle.
- div_active always reflects N.

## Timing
- Reset values: cfg_ready = 1, cfg_err = 0, clk_out = 0, clk_en = 0, busy = 0, div_active = DIV_RST. State is IDLE, cnt = 0, pend_vld = 0.
- All outputs are registered; none is combinationally derived from inputs.
- Start latency: run sampled high at edge k gives clk_out = 1 and clk_en = 1 after edge k+1.
- Period: consecutive clk_en pulses are exactly N cycles apart under a constant ratio.
- Ratio-change latency: the new N takes effect at the first boundary after acceptance. The first period with the new N begins at the cycle after that boundary edge.
- Stop latency: the controller reaches IDLE at the edge ending the period in progress. This is at most N cycles after run falls.
- cfg_err asserts in the cycle after the accepting edge.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously). Any pending ratio is lost.

## Test plan
- Reset, then run = 1 with DIV_RST = 4 → clk_en pulses every 4 cycles; clk_out pattern 1,1,0,0; div_active = 4.
- In RUN with N = 4, offer cfg_div = 5 at cnt = 1 → cfg_ready drops for the rest of the period. The next period is 5 cycles with clk_out pattern 1,1,1,0,0; div_active = 5 after the boundary.
- Offer cfg_div = 1 and then cfg_div = 0 → each is accepted, each gives a one-cycle cfg_err pulse, and N is unchanged.
- Deassert run at cnt = 1 with N = 6 → 4 more cycles of the period complete, then IDLE, clk_out = 0, busy = 0.
- Re-assert run during STOP_PEND → there is no gap; clk_en continues every N cycles.
- Assert rst_n = 0 mid-period with a pending ratio of 7 → outputs go to their reset values at once; after release, div_active = 4 and the ratio 7 is never applied.
